// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
//   Bundles the read ports, the issue handshake and the writeback bus of the
//   integer register file / scoreboard.
//   master modport : decode/issue + writeback side (drives addresses, issue
//                    fields and writeback data; observes read data, stall,
//                    scoreboard state).
//   slave modport  : the register file itself.
//   Signals:
//     rs1, rs2            read addresses
//     rs1_data, rs2_data  combinational read data (with writeback bypass)
//     issue_valid, issue_use_rs1, issue_use_rs2, issue_rd, issue_wr_en
//                         instruction presented for issue
//     stall               issue blocked this cycle
//     wb_valid, wb_rd, wb_data  writeback
//     pending             outstanding-write bits, bit 0 always 0
//     sb_err              sticky spurious-writeback flag
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  logic            issue_valid;
  logic            issue_use_rs1;
  logic            issue_use_rs2;
  logic [4:0]      issue_rd;
  logic            issue_wr_en;
  logic            stall;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic [31:0]     pending;
  logic            sb_err;

  modport master (
    output rs1, rs2,
    output issue_valid, issue_use_rs1, issue_use_rs2, issue_rd, issue_wr_en,
    output wb_valid, wb_rd, wb_data,
    input  rs1_data, rs2_data, stall, pending, sb_err
  );

  modport slave (
    input  rs1, rs2,
    input  issue_valid, issue_use_rs1, issue_use_rs2, issue_rd, issue_wr_en,
    input  wb_valid, wb_rd, wb_data,
    output rs1_data, rs2_data, stall, pending, sb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Integer register file x0..x31 with two combinational read ports, a
//   same-cycle writeback bypass and a pending-write scoreboard that stalls
//   issue on RAW/WAW hazards against outstanding writes.
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset (clears registers, scoreboard,
//          error flag; in-flight issue/writeback are discarded)
//     bus  regfile_scoreboard_if.slave (read ports, issue, writeback,
//          pending vector, sticky sb_err)
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);

  // x1..x31 only; x0 is a constant zero and has no storage.
  logic [XLEN-1:0] regs_reg [1:31];
  logic [31:0]     pending_reg;
  logic            sb_err_reg;

  logic [31:0]     clr;     // scoreboard bits cleared by this cycle's writeback
  logic [31:0]     set;     // scoreboard bit set by this cycle's accepted issue
  logic [31:0]     busy;    // pending bits still outstanding after the writeback
  logic            stall;
  logic            wb_live; // writeback to a real register

  assign wb_live = bus.wb_valid && (bus.wb_rd != 5'd0);

  always_comb begin
    clr = '0;
    if (wb_live) begin
      clr[bus.wb_rd] = 1'b1;
    end
  end

  // A hazard resolved by the same-cycle writeback does not stall; the bypass
  // on the read ports supplies the value.
  assign busy = pending_reg & ~clr;

  always_comb begin
    stall = 1'b0;
    if (bus.issue_valid) begin
      stall = (bus.issue_use_rs1 && busy[bus.rs1])
           || (bus.issue_use_rs2 && busy[bus.rs2])
           || (bus.issue_wr_en   && busy[bus.issue_rd]);
    end
  end

  always_comb begin
    set = '0;
    if (bus.issue_valid && !stall && bus.issue_wr_en && (bus.issue_rd != 5'd0)) begin
      set[bus.issue_rd] = 1'b1;
    end
  end

  // Set takes priority over clear: a new writer accepted in the same cycle
  // as the previous writer's writeback stays outstanding. Bit 0 is never
  // set or cleared, so it holds its reset value of 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= (pending_reg & ~clr) | set;
    end
  end

  // Writeback for a register with nothing outstanding is a protocol error.
  // The data is still written; the flag stays up until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_reg <= 1'b0;
    end else if (wb_live && !pending_reg[bus.wb_rd]) begin
      sb_err_reg <= 1'b1;
    end
  end

  genvar gi;

  // One flop bank per architectural register so the whole file clears on
  // reset and both read ports can see every entry combinationally.
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (bus.wb_valid && (bus.wb_rd == 5'(gi))) begin
          regs_reg[gi] <= bus.wb_data;
        end
      end
    end
  endgenerate

  // Read ports: x0 -> 0, else bypass a matching writeback, else stored value.
  logic [4:0] raddr [2];
  assign raddr[0] = bus.rs1;
  assign raddr[1] = bus.rs2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      logic [XLEN-1:0] data;
      always_comb begin
        data = '0;
        if (raddr[gi] != 5'd0) begin
          if (bus.wb_valid && (bus.wb_rd == raddr[gi])) begin
            data = bus.wb_data;
          end else begin
            data = regs_reg[raddr[gi]];
          end
        end
      end
    end
  endgenerate

  assign bus.rs1_data = g_read[0].data;
  assign bus.rs2_data = g_read[1].data;
  assign bus.stall    = stall;
  assign bus.pending  = pending_reg;
  assign bus.sb_err   = sb_err_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Directed stimulus for regfile_scoreboard. Each cycle the stimulus drives
//   the inputs shortly after the rising edge and queues the responses it
//   expects for that cycle; a monitor on the falling edge pops the queue and
//   compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int XLEN = 32;

  // Which DUT output an expectation refers to.
  localparam int K_RS1   = 0;
  localparam int K_RS2   = 1;
  localparam int K_STALL = 2;
  localparam int K_PEND  = 3;
  localparam int K_ERR   = 4;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  regfile_scoreboard_if #(.XLEN(XLEN)) bus ();

  regfile_scoreboard #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_mismatch = 0;

  // Monitor: every falling edge, check all expectations queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        K_RS1:   act = bus.rs1_data;
        K_RS2:   act = bus.rs2_data;
        K_STALL: act = {31'd0, bus.stall};
        K_PEND:  act = bus.pending;
        default: act = {31'd0, bus.sb_err};
      endcase
      n_compared++;
      if (act !== e.val) begin
        n_mismatch++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", e.name, act, e.val, $time);
      end else begin
        $display("ok   %s: 0x%08h (t=%0t)", e.name, act, $time);
      end
    end
  end

  task automatic expect_val(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs1           = 5'd0;
    bus.rs2           = 5'd0;
    bus.issue_valid   = 1'b0;
    bus.issue_use_rs1 = 1'b0;
    bus.issue_use_rs2 = 1'b0;
    bus.issue_rd      = 5'd0;
    bus.issue_wr_en   = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.wb_rd         = 5'd0;
    bus.wb_data       = '0;
  endtask

  task automatic issue(input logic use1, input logic [4:0] r1,
                       input logic use2, input logic [4:0] r2,
                       input logic wr, input logic [4:0] rd);
    bus.issue_valid   = 1'b1;
    bus.issue_use_rs1 = use1;
    bus.rs1           = r1;
    bus.issue_use_rs2 = use2;
    bus.rs2           = r2;
    bus.issue_wr_en   = wr;
    bus.issue_rd      = rd;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_data  = data;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state.
    idle();
    issue(1'b1, 5'd5, 1'b1, 5'd31, 1'b0, 5'd0);
    expect_val(K_RS1,   32'h0, "rst_x5");
    expect_val(K_RS2,   32'h0, "rst_x31");
    expect_val(K_PEND,  32'h0, "rst_pending");
    expect_val(K_ERR,   32'h0, "rst_sb_err");
    expect_val(K_STALL, 32'h0, "rst_stall");

    // Write/bypass on x7 (made outstanding first so no error is raised).
    step(); idle();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
    expect_val(K_STALL, 32'h0, "iss7_stall");
    step(); idle();
    expect_val(K_PEND, 32'h0000_0080, "iss7_pending");
    step(); idle();
    wb(5'd7, 32'hDEAD_BEEF);
    issue(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
    expect_val(K_RS1,   32'hDEAD_BEEF, "byp_rs1_x7");
    expect_val(K_RS2,   32'hDEAD_BEEF, "byp_rs2_x7");
    expect_val(K_STALL, 32'h0,         "byp_stall_clr");
    step(); idle();
    bus.rs1 = 5'd7;
    expect_val(K_RS1,  32'hDEAD_BEEF, "stored_x7");
    expect_val(K_PEND, 32'h0,         "wb7_pending");
    expect_val(K_ERR,  32'h0,         "wb7_sb_err");

    // Write to x0 is ignored, including the bypass.
    step(); idle();
    wb(5'd0, 32'h0000_1234);
    expect_val(K_RS1, 32'h0, "x0_bypass");
    step(); idle();
    expect_val(K_RS1,  32'h0, "x0_stored");
    expect_val(K_ERR,  32'h0, "x0_no_err");
    expect_val(K_PEND, 32'h0, "x0_pending");

    // RAW: producer rd=3 at cycle 0, consumer stalls cycles 1..4.
    step(); idle();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
    expect_val(K_STALL, 32'h0, "raw_prod_stall");
    step(); idle();
    issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    expect_val(K_STALL, 32'h1,         "raw_stall_c1");
    expect_val(K_PEND,  32'h0000_0008, "raw_pending");
    for (int c = 2; c <= 4; c++) begin
      step();
      expect_val(K_STALL, 32'h1, $sformatf("raw_stall_c%0d", c));
    end
    step();
    wb(5'd3, 32'h0000_0055);
    expect_val(K_STALL, 32'h0,         "raw_stall_c5");
    expect_val(K_RS1,   32'h0000_0055, "raw_bypass_c5");
    step(); idle();
    bus.rs1 = 5'd3;
    expect_val(K_PEND, 32'h0,         "raw_pending_c6");
    expect_val(K_RS1,  32'h0000_0055, "raw_stored_x3");

    // WAW and same-cycle set/clear on x9.
    step(); idle();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    step(); idle();
    expect_val(K_PEND, 32'h0000_0200, "waw_pending");
    step(); idle();
    wb(5'd9, 32'h0000_0099);
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    expect_val(K_STALL, 32'h0, "waw_setclr_stall");
    step(); idle();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    expect_val(K_PEND,  32'h0000_0200, "waw_set_wins");
    expect_val(K_STALL, 32'h1,         "waw_stall");
    step(); idle();
    bus.rs1 = 5'd9;
    expect_val(K_RS1,  32'h0000_0099, "waw_stored_x9");
    expect_val(K_PEND, 32'h0000_0200, "waw_pending_hold");

    // Spurious writeback to x12.
    step(); idle();
    wb(5'd12, 32'h00C0_FFEE);
    expect_val(K_ERR, 32'h0, "spur_err_same");
    step(); idle();
    bus.rs1 = 5'd12;
    expect_val(K_RS1, 32'h00C0_FFEE, "spur_stored_x12");
    expect_val(K_ERR, 32'h1,         "spur_err_set");
    step(); idle();
    expect_val(K_ERR, 32'h1, "spur_err_sticky");

    // Reset mid-operation: pending {3,9}, x4=0xA5, then rst with a writeback.
    step(); idle();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
    wb(5'd4, 32'h0000_00A5);
    step(); idle();
    bus.rs1 = 5'd4;
    expect_val(K_PEND, 32'h0000_0208, "mid_pending");
    expect_val(K_RS1,  32'h0000_00A5, "mid_x4");
    step(); idle();
    rst = 1'b1;
    wb(5'd4, 32'h0000_0077);
    step(); idle();
    rst = 1'b0;
    issue(1'b1, 5'd4, 1'b1, 5'd9, 1'b0, 5'd0);
    expect_val(K_RS1,   32'h0, "post_rst_x4");
    expect_val(K_RS2,   32'h0, "post_rst_x9");
    expect_val(K_PEND,  32'h0, "post_rst_pending");
    expect_val(K_ERR,   32'h0, "post_rst_sb_err");
    expect_val(K_STALL, 32'h0, "post_rst_stall");
    step(); idle();

    // Drain the expectation queue, bounded.
    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        step();
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_mismatch++;
        $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Integer register file with a pending-write scoreboard. It is the consumer of the decode-stage register fields: `rs1`/`rs2` are read here, and `rd` plus its write enable are tracked until writeback. The block holds x0..x31, serves two combinational read ports with writeback bypass, and stalls issue on RAW/WAW hazards against outstanding writes. It sits between decode/issue and the writeback stage of the core.

## Interface
- `XLEN`, 32, register data width
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `rs1`  in  5  read port 1 address
- `rs2`  in  5  read port 2 address
- `rs1_data`  out  XLEN  read port 1 data (combinational)
- `rs2_data`  out  XLEN  read port 2 data (combinational)
- `issue_valid`  in  1  an instruction is presented for issue this cycle
- `issue_use_rs1`  in  1  presented instruction reads rs1
- `issue_use_rs2`  in  1  presented instruction reads rs2
- `issue_rd`  in  5  destination of presented instruction
- `issue_wr_en`  in  1  presented instruction writes rd; decode already forces 0 for rd==0
- `stall`  out  1  issue blocked this cycle (combinational)
- `wb_valid`  in  1  writeback this cycle
- `wb_rd`  in  5  writeback destination
- `wb_data`  in  XLEN  writeback value
- `pending`  out  32  scoreboard bits, bit i = xi has an outstanding write; bit 0 always 0
- `sb_err`  out  1  sticky: writeback arrived for a register with no outstanding write

## Operation
- Storage: 31 XLEN-bit registers x1..x31. x0 is not stored and always reads 0. A write to x0 is ignored and never marks or clears anything.
- Read data: if the address is 0, return 0. Else if `wb_valid` and `wb_rd` equals the address, return `wb_data` (bypass). Else return the stored value.
- Writeback: when `wb_valid` and `wb_rd`!=0, store `wb_data` into x[wb_rd] at the clock edge and clear `pending[wb_rd]`.
- Clear-this-cycle: `clr[i] = wb_valid & (wb_rd==i) & (i!=0)`.
- Effective pending: `busy[i] = pending[i] & ~clr[i]`. A hazard resolved by the same-cycle writeback does not stall; the bypass supplies the data.
- Stall is asserted when `issue_valid` and any of the following hold:
  - `issue_use_rs1 & busy[rs1]`
  - `issue_use_rs2 & busy[rs2]`
  - `issue_wr_en & busy[issue_rd]` (WAW)
- Stall is 0 whenever `issue_valid`=0.
- Accept: when `issue_valid & ~stall & issue_wr_en & issue_rd!=0`, set `pending[issue_rd]` at the clock edge.
- Same index set and cleared in one cycle: set wins, so pending stays 1. The new writer is now outstanding.
- Error: when `wb_valid`, `wb_rd`!=0 and `pending[wb_rd]`=0, set `sb_err` at the clock edge. The data is still written and `sb_err` stays set until reset.
- No FSM. State is the register array, the 32-bit scoreboard vector and `sb_err`.

## Timing
- Reset (sync, `rst`=1 at an edge): x1..x31 <= 0, `pending` <= 0, `sb_err` <= 0. Writeback and issue are ignored during that edge.
- `rst` asserted with writes or issues in flight discards them. After reset, all reads return 0 and `stall`=0.
- Read latency: 0 cycles, combinational from `rs1`/`rs2`/`wb_*`.
- Write latency: 1 cycle. The stored value is visible the cycle after `wb_valid`; the bypass covers the same cycle.
- Scoreboard set: visible on `pending`/`stall` the cycle after accept.
- Scoreboard clear: affects `stall` in the same cycle as `wb_valid`.
- Issue is valid/stall: upstream holds the issue_* inputs stable while `stall`=1. The block keeps no issue state beyond `pending`.
- Back-to-back: a producer accepted in cycle N and a consumer of the same rd in cycle N+1 stalls until the writeback cycle, then issues in that cycle with bypassed data.

## Test plan
- Reset then read: assert `rst` 1 cycle. Read x5 and x31 -> 0; `pending`=0, `sb_err`=0, `stall`=0.
- Write/bypass: `wb_valid`, wb_rd=7, wb_data=0xDEADBEEF with rs1=7 -> `rs1_data`=0xDEADBEEF in the same cycle. Next cycle with `wb_valid`=0 -> still 0xDEADBEEF. A write to x0 of 0x1234 -> x0 reads 0.
- RAW stall: issue rd=3 (wr_en) at cycle 0 -> `pending[3]`=1 at cycle 1. Issue with use_rs1, rs1=3 -> `stall`=1 in cycles 1–4. Writeback x3=0x55 at cycle 5 -> `stall`=0 and rs1_data=0x55 in cycle 5; `pending[3]`=0 at cycle 6.
- WAW plus same-cycle set/clear: pending[9]=1. Writeback x9 and accept a new issue rd=9 in the same cycle -> stall=0; pending[9]=1 next cycle. With pending[9]=1 and no writeback, issue rd=9 -> stall=1.
- Spurious writeback: wb_rd=12 with pending[12]=0 -> x12 written; `sb_err`=1 next cycle and stays 1 until `rst`.
- Reset mid-operation: pending = bits {3,9}, x4=0xA5. Assert `rst` together with a `wb_valid` -> all pending=0, x4=0, the wb value is not stored, and stall=0 afterward.
